// File: rtl/hada_prim_sched_if.sv
// Request/response bundle between the requesters and the shared primitive unit.
interface hada_prim_sched_if #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
);
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ-1:0][1:0]   req_op;
  logic [NREQ-1:0][1:0]   req_width;
  logic [NREQ-1:0]        req_signed;
  logic [NREQ-1:0][63:0]  req_a;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [IDW-1:0]         rsp_id;
  logic [63:0]            rsp_data;
  logic                   rsp_err;

  modport master (
    output req_valid, req_op, req_width, req_signed, req_a, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_width, req_signed, req_a, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
  );
endinterface

// File: rtl/hada_prim_sched.sv
// Round-robin front end for one shared abs/signum/extend unit.
// IDLE grants combinationally, BUSY computes into the result register,
// HOLD presents the result until the consumer takes it.
module hada_prim_sched #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  hada_prim_sched_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;
  typedef enum logic [1:0] {OP_ABS, OP_SGN, OP_EXT, OP_RSV} op_t;

  typedef struct packed {
    logic [1:0]     op;
    logic [1:0]     width;
    logic           sgn;
    logic [63:0]    a;
    logic [IDW-1:0] id;
  } req_t;

  state_t         state;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] grant;
  logic           found;
  req_t           cap;

  // Truncate to the selected width, then sign- or zero-extend back to 64.
  function automatic logic [63:0] ext(input logic [63:0] v, input logic [1:0] w,
                                      input logic s);
    case (w)
      2'd0:    ext = {{56{s & v[7]}},  v[7:0]};
      2'd1:    ext = {{48{s & v[15]}}, v[15:0]};
      2'd2:    ext = {{32{s & v[31]}}, v[31:0]};
      default: ext = v;
    endcase
  endfunction

  // Returns {err, data}. Raw results are re-extended so that abs of the
  // most-negative value wraps back to itself at width w.
  function automatic logic [64:0] prim(input req_t r);
    logic [63:0] x;
    logic [63:0] raw;
    logic        neg;
    logic        err;
    x   = ext(r.a, r.width, r.sgn);
    neg = r.sgn & x[63];
    raw = '0;
    err = 1'b0;
    case (op_t'(r.op))
      OP_ABS:  raw = neg ? (64'd0 - x) : x;
      OP_SGN:  raw = neg ? '1 : {63'd0, (x != 64'd0)};
      OP_EXT:  raw = x;
      default: err = 1'b1;
    endcase
    prim = {err, ext(raw, r.width, r.sgn)};
  endfunction

  // First asserted request at or after rr_ptr, searching upward with wrap.
  always_comb begin
    found = 1'b0;
    grant = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && bus.req_valid[(int'(rr_ptr) + i) % NREQ]) begin
        found = 1'b1;
        grant = IDW'((int'(rr_ptr) + i) % NREQ);
      end
    end
  end

  assign bus.req_ready = (rst_n && state == IDLE && found) ? (NREQ'(1) << grant) : '0;

  // Control FSM with registered response outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      cap           <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= '0;
      bus.rsp_data  <= '0;
      bus.rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (found) begin
          cap.op    <= bus.req_op[grant];
          cap.width <= bus.req_width[grant];
          cap.sgn   <= bus.req_signed[grant];
          cap.a     <= bus.req_a[grant];
          cap.id    <= grant;
          rr_ptr    <= (grant == IDW'(NREQ - 1)) ? '0 : grant + IDW'(1);
          state     <= BUSY;
        end
        BUSY: begin
          {bus.rsp_err, bus.rsp_data} <= prim(cap);
          bus.rsp_id    <= cap.id;
          bus.rsp_valid <= 1'b1;
          state         <= HOLD;
        end
        HOLD: if (bus.rsp_ready) begin
          bus.rsp_valid <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
